// File: rtl/fht_ctrl_pkg.sv
// fht_ctrl_pkg
//   Shared types and helpers for the FHT address/control sequencer.
//   - e_seq_state     : sequencer phase encoding (also exported as a debug port)
//   - BUT_LAT_DEFAULT : default RAM-read + butterfly pipeline latency
//   - N_DEFAULT       : default transform length
//   - bitrev()        : reverse the low 'width' bits of an address
package fht_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } e_seq_state;

  localparam int unsigned BUT_LAT_DEFAULT = 4;
  localparam int unsigned N_DEFAULT       = 256;

  // Reverses bits [width-1:0] of addr; bits above width come back as 0.
  // Walking from the LSB and shifting the result left puts source bit i at
  // result position width-1-i.
  function automatic logic [31:0] bitrev(input logic [31:0] addr, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r = (r << 1) | ((addr >> i) & 32'd1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_wr_delay.sv
// fht_wr_delay
//   Fixed-latency shift register that turns the butterfly read strobe and
//   its address pair into the matching write-back strobe DEPTH cycles later.
//   The payload is opaque here; the sequencer packs {valid, addr_a, addr_b}.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low clear of every stage
//   din_i   : payload entering the line this cycle
//   dout_o  : payload that entered exactly DEPTH cycles ago (registered)
module fht_wr_delay #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 17
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fht_seq_ctrl.sv
// fht_seq_ctrl
//   Address/control sequencer for an in-place radix-2 FHT. Owns no data:
//   it loads N samples to bit-reversed addresses, then issues log2(N) stages
//   of N/2 butterfly read pairs (plus twiddle index), and replays each read
//   as a write-back BUT_LAT cycles later through fht_wr_delay.
// Ports:
//   iCLK, iRESET        : clock (rising edge), async active-low reset
//   iSTART              : start request, only looked at in IDLE
//   iLOAD_VALID         : sample present; accepted when oLOAD_RDY is also high
//   oLOAD_RDY/ADDR      : load window and bit-reversed write address
//   oRD_EN/ADDR_A/B     : butterfly read strobe and operand addresses
//   oTW_IDX, oSTAGE     : twiddle table index, current stage
//   oWR_EN/ADDR_A/B     : write-back strobe and addresses (delayed reads)
//   oBUSY, oDONE        : not-IDLE flag, one-cycle completion pulse
//   oDBG_STATE          : current sequencer state, for observation only
//
// Handshake: a load sample transfers on every rising edge where
// iLOAD_VALID && oLOAD_RDY; oLOAD_RDY does not depend on iLOAD_VALID, the
// address on oLOAD_ADDR belongs to the sample offered in that cycle, and a
// cycle with iLOAD_VALID low transfers nothing and leaves the address held.
module fht_seq_ctrl
  import fht_ctrl_pkg::*;
#(
  parameter  int unsigned N       = N_DEFAULT,
  parameter  int unsigned BUT_LAT = BUT_LAT_DEFAULT,
  localparam int unsigned A_W     = $clog2(N),
  localparam int unsigned S_W     = $clog2($clog2(N)) + 1
) (
  input  logic           iCLK,
  input  logic           iRESET,
  input  logic           iSTART,
  input  logic           iLOAD_VALID,
  output logic           oLOAD_RDY,
  output logic [A_W-1:0] oLOAD_ADDR,
  output logic           oRD_EN,
  output logic [A_W-1:0] oRD_ADDR_A,
  output logic [A_W-1:0] oRD_ADDR_B,
  output logic [A_W-2:0] oTW_IDX,
  output logic [S_W-1:0] oSTAGE,
  output logic           oWR_EN,
  output logic [A_W-1:0] oWR_ADDR_A,
  output logic [A_W-1:0] oWR_ADDR_B,
  output logic           oBUSY,
  output logic           oDONE,
  output e_seq_state     oDBG_STATE
);

  localparam int unsigned LOG2N = $clog2(N);
  localparam int unsigned D_W   = $clog2(BUT_LAT) + 1;
  localparam int unsigned PAY_W = 1 + 2 * A_W;

  localparam logic [A_W-1:0] LC_LAST    = A_W'(N - 1);
  localparam logic [A_W-2:0] J_LAST     = (A_W-1)'(N / 2 - 1);
  localparam logic [S_W-1:0] STAGE_LAST = S_W'(LOG2N - 1);
  localparam logic [D_W-1:0] DRAIN_LAST = D_W'(BUT_LAT - 1);

  // Butterfly address helpers. j is the butterfly index within a stage,
  // s the stage: half = 2^s, p = j mod half, g = j / half.
  function automatic logic [A_W-1:0] bf_mask(input logic [S_W-1:0] s);
    return (A_W'(1) << s) - A_W'(1);
  endfunction

  function automatic logic [A_W-1:0] bf_addr_a(input logic [A_W-2:0] j,
                                               input logic [S_W-1:0] s);
    logic [A_W-1:0] jw;
    jw = {1'b0, j};
    // g*2*half + p: shift the group bits up by one position, keep p in place
    return ((jw >> s) << (s + S_W'(1))) | (jw & bf_mask(s));
  endfunction

  function automatic logic [A_W-2:0] bf_tw(input logic [A_W-2:0] j,
                                           input logic [S_W-1:0] s);
    logic [A_W-1:0] p;
    p = {1'b0, j} & bf_mask(s);
    // p < 2^s, so p << (log2(N)-1-s) always fits in A_W-1 bits
    return (A_W-1)'(p << (S_W'(LOG2N - 1) - s));
  endfunction

  // State and counters
  e_seq_state     state_q;
  logic [A_W-1:0] lc_q;
  logic [A_W-2:0] j_q;
  logic [S_W-1:0] stage_q;
  logic [D_W-1:0] drain_q;

  // Registered outputs
  logic           load_rdy_q;
  logic [A_W-1:0] load_addr_q;
  logic           rd_en_q;
  logic [A_W-1:0] rd_addr_a_q;
  logic [A_W-1:0] rd_addr_b_q;
  logic [A_W-2:0] tw_idx_q;
  logic           busy_q;
  logic           done_q;

  // Next-value helpers
  logic [A_W-1:0] lc_d;
  logic [A_W-1:0] load_addr_d;
  logic [A_W-2:0] j_d;
  logic [S_W-1:0] stage_d;
  logic [A_W-2:0] bf_j_d;
  logic [S_W-1:0] bf_s_d;
  logic [A_W-1:0] bf_a_d;
  logic [A_W-1:0] bf_b_d;
  logic [A_W-2:0] bf_tw_d;

  always_comb begin
    lc_d        = lc_q + A_W'(1);
    load_addr_d = A_W'(bitrev(32'(lc_d), int'(A_W)));
    j_d         = j_q + (A_W-1)'(1);
    stage_d     = stage_q + S_W'(1);

    // The butterfly registered into the read outputs at the coming edge:
    // the next j while computing, the first j of the next stage when
    // leaving DRAIN, and (0, 0) when leaving LOAD.
    bf_j_d = '0;
    bf_s_d = '0;
    if (state_q == CALC) begin
      bf_j_d = j_d;
      bf_s_d = stage_q;
    end else if (state_q == DRAIN) begin
      bf_s_d = stage_d;
    end

    bf_a_d  = bf_addr_a(bf_j_d, bf_s_d);
    bf_b_d  = bf_a_d | (A_W'(1) << bf_s_d);
    bf_tw_d = bf_tw(bf_j_d, bf_s_d);
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= IDLE;
      lc_q        <= '0;
      j_q         <= '0;
      stage_q     <= '0;
      drain_q     <= '0;
      load_rdy_q  <= 1'b0;
      load_addr_q <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_idx_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iSTART) begin
            state_q     <= LOAD;
            lc_q        <= '0;
            load_rdy_q  <= 1'b1;
            load_addr_q <= '0;
            busy_q      <= 1'b1;
          end
        end

        LOAD: begin
          if (iLOAD_VALID) begin
            if (lc_q == LC_LAST) begin
              // Last sample: the first butterfly of stage 0 is issued
              // on the same edge that closes the load window.
              state_q     <= CALC;
              lc_q        <= '0;
              load_rdy_q  <= 1'b0;
              load_addr_q <= '0;
              j_q         <= '0;
              stage_q     <= '0;
              rd_en_q     <= 1'b1;
              rd_addr_a_q <= bf_a_d;
              rd_addr_b_q <= bf_b_d;
              tw_idx_q    <= bf_tw_d;
            end else begin
              lc_q        <= lc_d;
              load_addr_q <= load_addr_d;
            end
          end
        end

        CALC: begin
          // The read outputs currently show butterfly j_q.
          if (j_q == J_LAST) begin
            state_q     <= DRAIN;
            j_q         <= '0;
            drain_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_idx_q    <= '0;
          end else begin
            j_q         <= j_d;
            rd_addr_a_q <= bf_a_d;
            rd_addr_b_q <= bf_b_d;
            tw_idx_q    <= bf_tw_d;
          end
        end

        DRAIN: begin
          // BUT_LAT read-idle cycles: the last write of this stage lands in
          // the final DRAIN cycle, so the next stage never reads stale data.
          if (drain_q == DRAIN_LAST) begin
            drain_q <= '0;
            if (stage_q == STAGE_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= CALC;
              stage_q     <= stage_d;
              j_q         <= '0;
              rd_en_q     <= 1'b1;
              rd_addr_a_q <= bf_a_d;
              rd_addr_b_q <= bf_b_d;
              tw_idx_q    <= bf_tw_d;
            end
          end else begin
            drain_q <= drain_q + D_W'(1);
          end
        end

        DONE: begin
          state_q <= IDLE;
          stage_q <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Write-back: the read strobe and addresses replayed BUT_LAT cycles later,
  // regardless of state.
  logic [PAY_W-1:0] wr_payload;

  fht_wr_delay #(
    .DEPTH (BUT_LAT),
    .W     (PAY_W)
  ) u_wr_delay (
    .clk_i  (iCLK),
    .rst_ni (iRESET),
    .din_i  ({rd_en_q, rd_addr_a_q, rd_addr_b_q}),
    .dout_o (wr_payload)
  );

  assign {oWR_EN, oWR_ADDR_A, oWR_ADDR_B} = wr_payload;

  assign oLOAD_RDY  = load_rdy_q;
  assign oLOAD_ADDR = load_addr_q;
  assign oRD_EN     = rd_en_q;
  assign oRD_ADDR_A = rd_addr_a_q;
  assign oRD_ADDR_B = rd_addr_b_q;
  assign oTW_IDX    = tw_idx_q;
  assign oSTAGE     = stage_q;
  assign oBUSY      = busy_q;
  assign oDONE      = done_q;
  assign oDBG_STATE = state_q;

endmodule

// File: tb/tb_fht_seq_ctrl.sv
// tb_fht_seq_ctrl
//   Directed bench for fht_seq_ctrl: an N=8 instance for the hand-computed
//   vectors (load order, butterfly pairs, drain timing, abort, start
//   boundaries) and an N=256 instance for the full-length run.
module tb_fht_seq_ctrl;
  import fht_ctrl_pkg::*;

  localparam int BL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- N=8 instance ----------------
  logic       start8 = 1'b0, valid8 = 1'b0;
  logic       ld_rdy8, rd_en8, wr_en8, busy8, done8;
  logic [2:0] ld_addr8, rd_a8, rd_b8, wr_a8, wr_b8, stage8;
  logic [1:0] tw8;
  e_seq_state st8;

  fht_seq_ctrl #(.N(8), .BUT_LAT(BL)) u_dut8 (
    .iCLK(clk), .iRESET(rst_n), .iSTART(start8), .iLOAD_VALID(valid8),
    .oLOAD_RDY(ld_rdy8), .oLOAD_ADDR(ld_addr8),
    .oRD_EN(rd_en8), .oRD_ADDR_A(rd_a8), .oRD_ADDR_B(rd_b8),
    .oTW_IDX(tw8), .oSTAGE(stage8),
    .oWR_EN(wr_en8), .oWR_ADDR_A(wr_a8), .oWR_ADDR_B(wr_b8),
    .oBUSY(busy8), .oDONE(done8), .oDBG_STATE(st8)
  );

  // ---------------- N=256 instance ----------------
  logic       start256 = 1'b0, valid256 = 1'b0;
  logic       ld_rdy256, rd_en256, wr_en256, busy256, done256;
  logic [7:0] ld_addr256, rd_a256, rd_b256, wr_a256, wr_b256;
  logic [6:0] tw256;
  logic [3:0] stage256;
  e_seq_state st256;

  fht_seq_ctrl #(.N(256), .BUT_LAT(BL)) u_dut256 (
    .iCLK(clk), .iRESET(rst_n), .iSTART(start256), .iLOAD_VALID(valid256),
    .oLOAD_RDY(ld_rdy256), .oLOAD_ADDR(ld_addr256),
    .oRD_EN(rd_en256), .oRD_ADDR_A(rd_a256), .oRD_ADDR_B(rd_b256),
    .oTW_IDX(tw256), .oSTAGE(stage256),
    .oWR_EN(wr_en256), .oWR_ADDR_A(wr_a256), .oWR_ADDR_B(wr_b256),
    .oBUSY(busy256), .oDONE(done256), .oDBG_STATE(st256)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- expected tables (hand-computed, N=8) ----------------
  logic [2:0] tbl_ld [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [2:0] tbl_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  logic [2:0] tbl_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  logic [1:0] tbl_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
  // cycles since the previous read; 0 marks the first read of a transform,
  // 5 = four read-idle DRAIN cycles between stages
  logic [3:0] tbl_dl [12] = '{0, 1, 1, 1,  5, 1, 1, 1,  5, 1, 1, 1};

  typedef struct packed {
    logic [2:0] stage;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    logic [3:0] delta;
  } rd8_t;

  typedef struct packed {
    logic [31:0] due;
    logic [7:0]  a;
    logic [7:0]  b;
  } wr_t;

  typedef struct packed {
    logic [3:0] stage;
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] tw;
  } rd256_t;

  logic [2:0] exp_ld8_q[$];
  rd8_t       exp_rd8_q[$];
  wr_t        exp_wr8_q[$];
  int         exp_done8_q[$];
  int         t0_8 = 0, last_rd8 = 0;

  logic [7:0] exp_ld256_q[$];
  rd256_t     exp_rd256_q[$];
  wr_t        exp_wr256_q[$];
  int         exp_done256_q[$];
  int         t0_256 = 0;
  bit         first256 = 1'b0;
  int         n_wr256 = 0;

  // ---------------- monitor, N=8 ----------------
  always @(negedge clk) begin
    rd8_t e;
    wr_t  w;
    int   g;
    if (ld_rdy8 && valid8) begin
      if (exp_ld8_q.size() > 0) chk("ld_addr8", ld_addr8, exp_ld8_q.pop_front());
      else chk("ld_unexpected8", ld_rdy8, 0);
    end else if (ld_rdy8 && exp_ld8_q.size() > 0) begin
      chk("ld_addr_hold8", ld_addr8, exp_ld8_q[0]);
    end
    if (wr_en8) begin
      if (exp_wr8_q.size() > 0) begin
        w = exp_wr8_q.pop_front();
        chk("wr_cycle8", cyc, w.due);
        chk("wr_a8", wr_a8, w.a);
        chk("wr_b8", wr_b8, w.b);
      end else chk("wr_unexpected8", wr_en8, 0);
    end
    if (rd_en8) begin
      if (exp_rd8_q.size() > 0) begin
        e = exp_rd8_q.pop_front();
        chk("rd_stage8", stage8, e.stage);
        chk("rd_a8", rd_a8, e.a);
        chk("rd_b8", rd_b8, e.b);
        chk("rd_tw8", tw8, e.tw);
        if (e.delta == 0) t0_8 = cyc;
        else chk("rd_gap8", cyc - last_rd8, e.delta);
        last_rd8 = cyc;
        exp_wr8_q.push_back('{due: 32'(cyc + BL), a: 8'(rd_a8), b: 8'(rd_b8)});
      end else chk("rd_unexpected8", rd_en8, 0);
    end
    if (done8) begin
      if (exp_done8_q.size() > 0) begin
        g = exp_done8_q.pop_front();
        chk("done_gap8", cyc - t0_8, g);
      end else chk("done_unexpected8", done8, 0);
    end
  end

  // ---------------- monitor, N=256 ----------------
  always @(negedge clk) begin
    rd256_t e;
    wr_t    w;
    if (ld_rdy256 && valid256) begin
      if (exp_ld256_q.size() > 0) chk("ld_addr256", ld_addr256, exp_ld256_q.pop_front());
      else chk("ld_unexpected256", ld_rdy256, 0);
    end
    if (wr_en256) begin
      n_wr256++;
      if (exp_wr256_q.size() > 0) begin
        w = exp_wr256_q.pop_front();
        chk("wr256", {32'(cyc), wr_a256, wr_b256}, {w.due, w.a, w.b});
      end else chk("wr_unexpected256", wr_en256, 0);
    end
    if (rd_en256) begin
      if (exp_rd256_q.size() > 0) begin
        e = exp_rd256_q.pop_front();
        chk("rd256", {stage256, rd_a256, rd_b256, tw256}, e);
        if (first256) begin
          t0_256   = cyc;
          first256 = 1'b0;
        end
        exp_wr256_q.push_back('{due: 32'(cyc + BL), a: rd_a256, b: rd_b256});
      end else chk("rd_unexpected256", rd_en256, 0);
    end
    if (done256) begin
      if (exp_done256_q.size() > 0) chk("done_gap256", cyc - t0_256, exp_done256_q.pop_front());
      else chk("done_unexpected256", done256, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect8();
    for (int i = 0; i < 12; i++) begin
      exp_rd8_q.push_back('{stage: 3'(i / 4), a: tbl_a[i], b: tbl_b[i],
                            tw: tbl_tw[i], delta: tbl_dl[i]});
    end
    exp_done8_q.push_back(24);
  endtask

  // Offers the eight samples; a set bit in gap_mask inserts one idle cycle
  // before that sample.
  task automatic load8(input logic [7:0] gap_mask);
    for (int k = 0; k < 8; k++) exp_ld8_q.push_back(tbl_ld[k]);
    for (int k = 0; k < 8; k++) begin
      if (gap_mask[k]) begin
        valid8 = 1'b0;
        chk("ld_rdy_stall8", ld_rdy8, 1);
        tick();
      end
      chk("ld_rdy8", ld_rdy8, 1);
      valid8 = 1'b1;
      tick();
    end
    valid8 = 1'b0;
    chk("ld_rdy_drop8", ld_rdy8, 0);
  endtask

  task automatic wait_done8(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    if (!seen) chk("done_timeout8", done8, 1);
  endtask

  task automatic run8(input logic [7:0] gap_mask);
    push_expect8();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    load8(gap_mask);
    wait_done8(200);
    tick();
  endtask

  function automatic logic [7:0] tb_bitrev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = x[i];
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit seen;

    // reset / idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ld_rdy", ld_rdy8, 0);
    chk("rst_ld_addr", ld_addr8, 0);
    chk("rst_rd_en", rd_en8, 0);
    chk("rst_rd_a", rd_a8, 0);
    chk("rst_rd_b", rd_b8, 0);
    chk("rst_tw", tw8, 0);
    chk("rst_stage", stage8, 0);
    chk("rst_wr_en", wr_en8, 0);
    chk("rst_wr_a", wr_a8, 0);
    chk("rst_wr_b", wr_b8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_state", st8, IDLE);
    chk("rst_busy256", busy256, 0);
    for (int i = 0; i < 3; i++) begin
      valid8 = 1'b1;
      tick();
      chk("idle_valid_busy", busy8, 0);
      chk("idle_valid_rdy", ld_rdy8, 0);
    end
    valid8 = 1'b0;
    tick();

    // load with gaps before samples 3 and 6, full compute
    push_expect8();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    load8(8'b0010_0100);
    wait_done8(200);
    chk("done_busy_hi", busy8, 1);
    tick();
    chk("after_done_busy", busy8, 0);
    chk("after_done_pulse", done8, 0);
    chk("after_done_state", st8, IDLE);

    // start pulse during CALC is ignored
    push_expect8();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    load8(8'b0000_0000);
    tick();
    chk("calc_state", st8, CALC);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("calc_start_ignored", ld_rdy8, 0);
    wait_done8(200);
    tick();
    tick();
    chk("no_restart_rdy", ld_rdy8, 0);
    chk("no_restart_busy", busy8, 0);

    // start held high through DONE: new LOAD only after IDLE
    push_expect8();
    start8 = 1'b1;
    tick();
    load8(8'b0000_0000);
    wait_done8(200);
    tick();
    chk("b2b_idle_rdy", ld_rdy8, 0);
    chk("b2b_idle_busy", busy8, 0);
    tick();
    chk("b2b_load_rdy", ld_rdy8, 1);
    chk("b2b_load_busy", busy8, 1);
    start8 = 1'b0;
    push_expect8();
    load8(8'b0000_0000);
    wait_done8(200);
    tick();

    // abort in the middle of stage 1
    push_expect8();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    load8(8'b0000_0000);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rd_en8 && stage8 == 3'd1 && rd_a8 == 3'd1) seen = 1'b1;
    end
    if (!seen) chk("abort_wait_stage1", stage8, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ld_rdy", ld_rdy8, 0);
    chk("abort_ld_addr", ld_addr8, 0);
    chk("abort_rd_en", rd_en8, 0);
    chk("abort_rd_a", rd_a8, 0);
    chk("abort_rd_b", rd_b8, 0);
    chk("abort_tw", tw8, 0);
    chk("abort_stage", stage8, 0);
    chk("abort_wr_en", wr_en8, 0);
    chk("abort_wr_a", wr_a8, 0);
    chk("abort_busy", busy8, 0);
    chk("abort_state", st8, IDLE);
    exp_rd8_q.delete();
    exp_wr8_q.delete();
    exp_done8_q.delete();
    exp_ld8_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) tick();
    run8(8'b1000_0001);

    // N=256 full run
    for (int i = 0; i < 256; i++) exp_ld256_q.push_back(tb_bitrev8(8'(i)));
    for (int s = 0; s < 8; s++) begin
      int half;
      half = 1 << s;
      for (int g = 0; g < (128 >> s); g++) begin
        for (int p = 0; p < half; p++) begin
          exp_rd256_q.push_back('{stage: 4'(s), a: 8'(g * 2 * half + p),
                                  b: 8'(g * 2 * half + p + half),
                                  tw: 7'(p << (7 - s))});
        end
      end
    end
    exp_done256_q.push_back(1056);
    first256 = 1'b1;
    start256 = 1'b1;
    tick();
    start256 = 1'b0;
    chk("ld_rdy256", ld_rdy256, 1);
    valid256 = 1'b1;
    repeat (256) tick();
    valid256 = 1'b0;
    chk("ld_rdy_drop256", ld_rdy256, 0);
    seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge clk);
      if (done256) seen = 1'b1;
    end
    if (!seen) chk("done_timeout256", done256, 1);
    repeat (10) tick();

    // leftovers
    chk("rd8_left", exp_rd8_q.size(), 0);
    chk("wr8_left", exp_wr8_q.size(), 0);
    chk("done8_left", exp_done8_q.size(), 0);
    chk("ld8_left", exp_ld8_q.size(), 0);
    chk("rd256_left", exp_rd256_q.size(), 0);
    chk("wr256_left", exp_wr256_q.size(), 0);
    chk("done256_left", exp_done256_q.size(), 0);
    chk("ld256_left", exp_ld256_q.size(), 0);
    chk("wr256_count", n_wr256, 1024);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
